// File: rtl/axi_lite_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : axi_lite_ram
// Description : AXI4-Lite slave backed by a 2^ADDR_W x 32-bit RAM.
//               Optional macro AXI_LITE_RAM_RANGE_CHECK_EN adds SLVERR
//               responses for addresses outside the RAM window.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module axi_lite_ram #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] AWdata,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [2:0]  AWprot,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  input  logic        Wvalid,
  output logic        Wready,
  output logic [1:0]  Bresp,
  output logic        Bvalid,
  input  logic        Bready,
  input  logic [31:0] ARdata,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [2:0]  ARprot,
  output logic [31:0] Rdata,
  output logic [1:0]  Rresp,
  output logic        Rvalid,
  input  logic        Rready
);

  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  logic [31:0] mem [DEPTH];

  // Write-path holding registers
  logic        aw_held, w_held;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic        aw_held_nxt, w_held_nxt, bvalid_nxt;
  logic        do_write;

  // Read path
  rstate_t     r_state, r_state_nxt;
  logic        ar_fire;

  logic [31:0] aw_off, ar_off;
  logic [ADDR_W-1:0] aw_idx, ar_idx;
  logic        aw_ok, ar_ok;
  logic        unused_bits;

  assign aw_off = aw_addr - BASE_ADDR;
  assign ar_off = ARdata - BASE_ADDR;
  assign aw_idx = aw_off[ADDR_W+1:2];
  assign ar_idx = ar_off[ADDR_W+1:2];
  assign unused_bits = ^{AWprot, ARprot, aw_off, ar_off};

`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
  // 33-bit offset so addresses below the base and a window that wraps past
  // 2^32 are both classified correctly.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !off[32] && ((off[31:0] >> (ADDR_W + 2)) == 32'd0);
  endfunction

  assign aw_ok = in_range(aw_addr);
  assign ar_ok = in_range(ARdata);
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  assign do_write = aw_held && w_held && !Bvalid;

  always_comb begin
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    bvalid_nxt  = Bvalid;
    if (AWvalid && AWready) aw_held_nxt = 1'b1;
    if (Wvalid && Wready)   w_held_nxt  = 1'b1;
    if (do_write) begin
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
    end
    if (Bvalid && Bready) bvalid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      AWready <= 1'b0;
      Wready  <= 1'b0;
      Bvalid  <= 1'b0;
      Bresp   <= RESP_OKAY;
    end else begin
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      Bvalid  <= bvalid_nxt;
      // Each channel re-opens only once its own beat and the B response clear.
      AWready <= !aw_held_nxt && !bvalid_nxt;
      Wready  <= !w_held_nxt && !bvalid_nxt;
      if (AWvalid && AWready) aw_addr <= AWdata;
      if (Wvalid && Wready) begin
        w_data <= Wdata;
        w_strb <= Wstrb;
      end
      if (do_write) Bresp <= aw_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && aw_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  assign ar_fire = ARvalid && ARready;

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
      R_DATA:  if (Rready)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      ARready <= 1'b0;
      Rvalid  <= 1'b0;
      Rdata   <= '0;
      Rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      ARready <= (r_state_nxt == R_IDLE);
      Rvalid  <= (r_state_nxt == R_DATA);
      if (ar_fire) begin
        Rdata <= ar_ok ? mem[ar_idx] : 32'h0;
        Rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_axi_lite_ram
// Description : Directed scoreboard bench for axi_lite_ram.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_axi_lite_ram;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] AWdata, Wdata, ARdata;
  logic        AWvalid, Wvalid, ARvalid, Bready, Rready;
  logic [2:0]  AWprot, ARprot;
  logic [3:0]  Wstrb;
  logic        AWready, Wready, ARready, Bvalid, Rvalid;
  logic [1:0]  Bresp, Rresp;
  logic [31:0] Rdata;

  int total = 0;
  int bad   = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [1:0]  eb;
  logic [33:0] er;

  always #5 clk = ~clk;

  axi_lite_ram dut (
    .clk(clk), .rstn(rstn),
    .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
    .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
    .Bresp(Bresp), .Bvalid(Bvalid), .Bready(Bready),
    .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
    .Rdata(Rdata), .Rresp(Rresp), .Rvalid(Rvalid), .Rready(Rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake will occur at the next rising edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (Bvalid && Bready) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          eb = bq.pop_front();
          check("bresp", {30'h0, Bresp}, {30'h0, eb});
        end
      end
      if (Rvalid && Rready) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else begin
          er = rq.pop_front();
          check("rdata", Rdata, er[31:0]);
          check("rresp", {30'h0, Rresp}, {30'h0, er[33:32]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(AWready && Wready && ARready && !Bvalid && !Rvalid)) begin
      tick();
      n++;
      if (n > 50) begin
        check("idle_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic write_both(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
    int n = 0;
    bq.push_back(resp);
    AWdata = a; Wdata = d; Wstrb = s; AWvalid = 1'b1; Wvalid = 1'b1;
    while (!(AWready && Wready)) begin
      tick();
      n++;
      if (n > 50) begin
        check("aw_w_timeout", 0, 1);
        break;
      end
    end
    tick();
    AWvalid = 1'b0; Wvalid = 1'b0;
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n = 0;
    rq.push_back({resp, d});
    ARdata = a; ARvalid = 1'b1;
    while (!ARready) begin
      tick();
      n++;
      if (n > 50) begin
        check("ar_timeout", 0, 1);
        break;
      end
    end
    tick();
    ARvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    AWdata = '0; Wdata = '0; ARdata = '0; Wstrb = '0;
    AWvalid = 0; Wvalid = 0; ARvalid = 0; Bready = 1; Rready = 1;
    AWprot = 3'b000; ARprot = 3'b000;

    // Reset state
    #22;
    check("reset_ctrl", {27'h0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'h0);
    check("reset_resp", {28'h0, Bresp, Rresp}, 32'h0);
    check("reset_rdata", Rdata, 32'h0);
    @(negedge clk); rstn = 1'b1;
    tick();
    check("post_reset_ready", {29'h0, AWready, Wready, ARready}, 32'h7);

    // Same-cycle AW/W, B one cycle later, then readback
    write_both(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
    check("b_lat0", {31'h0, Bvalid}, 0);
    tick();
    check("b_lat1", {31'h0, Bvalid}, 1);
    wait_idle();
    read(32'h10, 32'hDEAD_BEEF, 2'b00);
    check("r_lat1", {31'h0, Rvalid}, 1);
    check("r_direct", Rdata, 32'hDEAD_BEEF);
    wait_idle();

    // W ahead of AW, partial strobe
    write_both(32'h20, 32'hFFFF_FFFF, 4'hF, 2'b00);
    wait_idle();
    bq.push_back(2'b00);
    Wdata = 32'h1122_3344; Wstrb = 4'b0101; Wvalid = 1'b1;
    tick();
    Wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("w_held_wready", {31'h0, Wready}, 0);
      check("w_held_bvalid", {31'h0, Bvalid}, 0);
      tick();
    end
    AWdata = 32'h20; AWvalid = 1'b1;
    tick();
    AWvalid = 1'b0;
    check("w_wready_after_aw", {30'h0, Wready, AWready}, 0);
    wait_idle();
    read(32'h20, 32'hFF22_FF44, 2'b00);
    wait_idle();

    // Rready stall
    Rready = 1'b0;
    read(32'h20, 32'hFF22_FF44, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check("stall_rdata", Rdata, 32'hFF22_FF44);
      check("stall_ctrl", {30'h0, ARready, Rvalid}, 32'h1);
      tick();
    end
    Rready = 1'b1;
    tick();
    check("stall_release", {30'h0, ARready, Rvalid}, 32'h2);
    wait_idle();

    // Zero strobe leaves data intact
    write_both(32'h40, 32'hCAFE_BABE, 4'hF, 2'b00);
    wait_idle();
    write_both(32'h40, 32'h0000_0000, 4'h0, 2'b00);
    wait_idle();
    read(32'h40, 32'hCAFE_BABE, 2'b00);
    wait_idle();

    // Read and write to the same word on the same edge returns old data
    write_both(32'h50, 32'h1111_1111, 4'hF, 2'b00);
    wait_idle();
    write_both(32'h50, 32'h2222_2222, 4'hF, 2'b00);
    rq.push_back({2'b00, 32'h1111_1111});
    ARdata = 32'h50; ARvalid = 1'b1;
    tick();
    ARvalid = 1'b0;
    wait_idle();
    read(32'h50, 32'h2222_2222, 2'b00);
    wait_idle();

    // Out-of-window address
    write_both(32'h0, 32'hA5A5_A5A5, 4'hF, 2'b00);
    wait_idle();
`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
    write_both(32'h1000, 32'h1234_5678, 4'hF, 2'b10);
    wait_idle();
    read(32'h1000, 32'h0, 2'b10);
    wait_idle();
    read(32'h0, 32'hA5A5_A5A5, 2'b00);
    wait_idle();
`else
    write_both(32'h1000, 32'h1234_5678, 4'hF, 2'b00);
    wait_idle();
    read(32'h0, 32'h1234_5678, 2'b00);
    wait_idle();
`endif

    // Reset with AW held and W pending
    write_both(32'h30, 32'h0BAD_F00D, 4'hF, 2'b00);
    wait_idle();
    AWdata = 32'h30; AWvalid = 1'b1;
    tick();
    AWvalid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midreset_ctrl", {27'h0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'h0);
    @(negedge clk); rstn = 1'b1;
    tick();
    check("midreset_ready", {29'h0, AWready, Wready, ARready}, 32'h7);
    Wdata = 32'hFFFF_FFFF; Wstrb = 4'hF; Wvalid = 1'b1;
    tick();
    Wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("aw_discarded", {31'h0, Bvalid}, 0);
      tick();
    end
    bq.push_back(2'b00);
    AWdata = 32'h34; AWvalid = 1'b1;
    tick();
    AWvalid = 1'b0;
    wait_idle();
    read(32'h30, 32'h0BAD_F00D, 2'b00);
    wait_idle();
    read(32'h34, 32'hFFFF_FFFF, 2'b00);
    wait_idle();

    tick();
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_ram.md
AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 Parameter ADDR_W, default 10: word-address bits; depth = 2^ADDR_W 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte base address of the RAM window.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rstn  in  1  reset; asynchronous, active-low.
REQ-005 AWdata  in  32  write byte address.
REQ-006 AWvalid / AWready  in / out  1  write-address handshake.
REQ-007 AWprot / ARprot  in  3  accepted and ignored.
REQ-008 Wdata  in  32  write data.
REQ-009 Wstrb  in  4  byte-lane enables.
REQ-010 Wvalid / Wready  in / out  1  write-data handshake.
REQ-011 Bresp  out  2  write response: 00 OKAY, 10 SLVERR.
REQ-012 Bvalid / Bready  out / in  1  write-response handshake.
REQ-013 ARdata  in  32  read byte address.
REQ-014 ARvalid / ARready  in / out  1  read-address handshake.
REQ-015 Rdata  out  32  read data.
REQ-016 Rresp  out  2  read response: 00 OKAY, 10 SLVERR.
REQ-017 Rvalid / Rready  out / in  1  read-data handshake.

Function
REQ-018 Handshake = valid and ready both high at a rising edge; ready outputs are registered.
REQ-019 Word index = (addr - BASE_ADDR)[ADDR_W+1:2]; addr[1:0] ignored.
REQ-020 Write path: independent holding registers for AW and W; either may complete first or both in the same edge.
REQ-021 AWready drops at the edge of its own handshake and stays low until the B handshake. Wready behaves the same way.
REQ-022 When both AW and W are held, the write occurs at the next edge E: byte lane i is written iff Wstrb[i]=1. Bvalid and Bresp are set at E.
REQ-023 Wstrb=4'b0000: no bytes change; Bresp=00.
REQ-024 Bvalid and Bresp are held until a B handshake. On that edge Bvalid goes 0 and AWready/Wready go 1.
REQ-025 Read FSM states: R_IDLE (ARready=1) and R_DATA (Rvalid=1, ARready=0).
REQ-026 AR handshake at edge E: RAM read synchronously; at E Rdata/Rresp are loaded, Rvalid goes 1, and state moves to R_DATA (1-cycle latency).
REQ-027 In R_DATA: Rdata and Rresp stay stable while Rready=0. An R handshake returns to R_IDLE with Rvalid=0 and ARready=1 at that edge.
REQ-028 Read and write paths operate concurrently. A read and a write to the same word at the same edge return the old data.
REQ-029 At most one outstanding read and one outstanding write; no further AW/W/AR is accepted until the matching response handshakes.

Reset
REQ-030 rstn low, asynchronous: AWready=0, Wready=0, ARready=0, Bvalid=0, Rvalid=0, Bresp=00, Rresp=00, Rdata=0; holding registers cleared; read FSM enters R_IDLE.
REQ-031 First rising edge with rstn high: AWready, Wready and ARready go to 1.
REQ-032 Reset mid-transaction: held AW/W are discarded without a RAM write; pending B/R responses are dropped.
REQ-033 RAM contents are not reset.

Configuration
REQ-034 Macro AXI_LITE_RAM_RANGE_CHECK_EN defined:
- addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^ADDR_W gives SLVERR (10).
- Errored write: no write, Bresp=10.
- Errored read: Rdata=0, Rresp=10.
REQ-035 Macro AXI_LITE_RAM_RANGE_CHECK_EN not defined: upper address bits are ignored (aliasing); Bresp and Rresp are always 00.

Verification
REQ-036 AW=0x10 and W=0xDEADBEEF/Wstrb=F in the same cycle; Bready=1 -> Bvalid exactly 1 cycle after the handshake with Bresp=00. Then AR=0x10 -> Rvalid 1 cycle later with Rdata=0xDEADBEEF.
REQ-037 W handshakes 3 cycles before AW; Wstrb=4'b0101, Wdata=0x11223344, over 0xFFFFFFFF at 0x20 -> read returns 0xFF22FF44; Wready stays low until B completes.
REQ-038 Rready held low 5 cycles after Rvalid -> Rdata stable, ARready=0 throughout; after the handshake, ARready=1 in the same edge.
REQ-039 Macro defined, BASE_ADDR=0, ADDR_W=10: write to 0x1000 -> Bresp=10 and 0x0000 unchanged; read 0x1000 -> Rdata=0, Rresp=10. Macro undefined: the write aliases to 0x0000 with Bresp=00.
REQ-040 rstn pulsed low while AW is held and W is pending -> all valids/readies 0 immediately; after release, the target word is unchanged and readies=1 after one edge.
